// File: rtl/adder28_arb_pkg.sv
// adder28_arb_pkg
// Shared constants for the arbitrated adder slice:
//   ADD_W      - operand/result width of the adder datapath (fixed 28)
//   N_REQ_DEF  - default number of requesters sharing the adder
//   id_width() - width of a requester index (clog2 of the count, min 1)
package adder28_arb_pkg;

    localparam int ADD_W     = 28;
    localparam int N_REQ_DEF = 4;

    // A single requester still needs a 1-bit index so ports never collapse to zero width.
    function automatic int id_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/adder28_arb_rr_arb.sv
// rr_arb
// Combinational round-robin grant: the first asserted request found when
// searching upward from ptr, wrapping modulo N, receives a one-hot grant.
// Ports:
//   req   - request vector
//   ptr   - search start index (always < N)
//   grant - one-hot grant, zero when no request is asserted
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder28_un.sv
// adder28_un
// Registered unsigned adder: S <= (A + B) mod 2^W when CE is high.
// Ports:
//   CLK  - clock
//   SCLR - synchronous active-high clear of the sum register
//   CE   - load enable for the sum register
//   A, B - operands
//   S    - registered sum, carry out discarded
module adder28_un #(
    parameter int W = 28
) (
    input  logic         CLK,
    input  logic         SCLR,
    input  logic         CE,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] S
);

    logic [W-1:0] sum_reg;

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            sum_reg <= '0;
        end else if (CE) begin
            sum_reg <= A + B;
        end
    end

    assign S = sum_reg;

endmodule

// File: rtl/adder28_arb.sv
// adder28_arb
// N_REQ requesters share one registered adder. A round-robin arbiter picks one
// valid requester whenever the single result slot is free; the selected
// operands load the adder and the result is presented one cycle later.
// Ports:
//   CLK, SCLR           - clock, synchronous active-high reset
//   REQ_VALID/REQ_READY - per-requester handshake (READY one-hot or zero)
//   REQ_A, REQ_B        - packed operands, requester i at [i*W +: W]
//   RES_VALID/RES_READY - result handshake
//   RES_S, RES_ID       - sum and owning requester index
//   BUSY                - any request pending or a result held
//   DONE_CNT            - saturating count of result handshakes
module adder28_arb
    import adder28_arb_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    parameter  int W     = ADD_W,
    parameter  int CW    = 16,
    localparam int IW    = id_width(N_REQ)
) (
    input  logic               CLK,
    input  logic               SCLR,
    input  logic [N_REQ-1:0]   REQ_VALID,
    output logic [N_REQ-1:0]   REQ_READY,
    input  logic [N_REQ*W-1:0] REQ_A,
    input  logic [N_REQ*W-1:0] REQ_B,
    output logic               RES_VALID,
    input  logic               RES_READY,
    output logic [W-1:0]       RES_S,
    output logic [IW-1:0]      RES_ID,
    output logic               BUSY,
    output logic [CW-1:0]      DONE_CNT
);

    logic             res_valid_reg, res_valid_next;
    logic [IW-1:0]    res_id_reg;
    logic [IW-1:0]    ptr_reg, ptr_next;
    logic [CW-1:0]    done_cnt_reg;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic             slot_free;
    logic             req_hs;
    logic             res_hs;
    logic [W-1:0]     a_sel, b_sel;
    logic [W-1:0]     a_term [N_REQ];
    logic [W-1:0]     b_term [N_REQ];

    rr_arb #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_arb (
        .req   (REQ_VALID),
        .ptr   (ptr_reg),
        .grant (grant)
    );

    // The slot frees up in the same cycle the held result is consumed, which
    // is what lets back-to-back operations run at one per cycle.
    assign slot_free = !res_valid_reg || RES_READY;
    assign REQ_READY = (slot_free && !SCLR) ? grant : '0;
    assign req_hs    = |REQ_READY;
    assign res_hs    = res_valid_reg && RES_READY;

    // AND-OR operand mux keyed by the one-hot grant.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_opmask
        assign a_term[gi] = REQ_A[gi*W +: W] & {W{grant[gi]}};
        assign b_term[gi] = REQ_B[gi*W +: W] & {W{grant[gi]}};
    end

    always_comb begin
        a_sel     = '0;
        b_sel     = '0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            a_sel = a_sel | a_term[i];
            b_sel = b_sel | b_term[i];
            if (grant[i]) begin
                grant_idx = IW'(i);
            end
        end
    end

    adder28_un #(
        .W (ADD_W)
    ) u_add (
        .CLK  (CLK),
        .SCLR (SCLR),
        .CE   (req_hs),
        .A    (a_sel),
        .B    (b_sel),
        .S    (RES_S)
    );

    always_comb begin
        res_valid_next = res_valid_reg;
        ptr_next       = ptr_reg;
        if (req_hs) begin
            res_valid_next = 1'b1;
            ptr_next       = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
        end else if (res_hs) begin
            res_valid_next = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            res_valid_reg <= 1'b0;
            res_id_reg    <= '0;
            ptr_reg       <= '0;
            done_cnt_reg  <= '0;
        end else begin
            res_valid_reg <= res_valid_next;
            ptr_reg       <= ptr_next;
            if (req_hs) begin
                res_id_reg <= grant_idx;
            end
            if (res_hs && (done_cnt_reg != {CW{1'b1}})) begin
                done_cnt_reg <= done_cnt_reg + CW'(1);
            end
        end
    end

    assign RES_VALID = res_valid_reg;
    assign RES_ID    = res_id_reg;
    assign DONE_CNT  = done_cnt_reg;
    assign BUSY      = (|REQ_VALID) || res_valid_reg;

endmodule

// File: doc/adder28_arb.md
ADDER28_ARB -- requirements
Module: adder28_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one adder (2..8).
REQ-002 Parameter W, default 28, operand/result width in bits.
REQ-003 Parameter CW, default 16, width of the completed-operation counter.
REQ-004 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-005 SCLR  input  1  reset; synchronous, active-high.
REQ-006 REQ_VALID  input  N_REQ  per-requester operation request.
REQ-007 REQ_READY  output  N_REQ  per-requester accept; one-hot or zero.
REQ-008 REQ_A  input  N_REQ*W  packed operand A; requester i at bits [i*W +: W].
REQ-009 REQ_B  input  N_REQ*W  packed operand B; same packing as REQ_A.
REQ-010 RES_VALID  output  1  result available.
REQ-011 RES_READY  input  1  result consumer accept.
REQ-012 RES_S  output  W  sum (A+B) mod 2^W.
REQ-013 RES_ID  output  clog2(N_REQ)  index of the requester that owns RES_S.
REQ-014 BUSY  output  1  high when any REQ_VALID is high or RES_VALID is high.
REQ-015 DONE_CNT  output  CW  count of completed result handshakes.

Function
REQ-016 Handshake: a request transfers on the cycle where REQ_VALID[i] and REQ_READY[i] are both high; a result transfers on the cycle where RES_VALID and RES_READY are both high.
REQ-017 Requesters hold REQ_VALID and their operands stable until accepted; the block does not need to tolerate withdrawal.
REQ-018 Slot free = !RES_VALID | RES_READY; REQ_READY is all-zero when the slot is not free.
REQ-019 When the slot is free, REQ_READY asserts for exactly one valid requester, chosen round-robin: search starts at index PTR and wraps modulo N_REQ.
REQ-020 PTR resets to 0; after a request handshake with requester g, PTR becomes (g+1) mod N_REQ; otherwise PTR is unchanged.
REQ-021 REQ_READY may depend combinationally on REQ_VALID, RES_VALID and RES_READY; it does not depend on the operands.
REQ-022 Latency: the operands accepted at edge k produce RES_VALID=1 with RES_S and RES_ID valid from edge k to the next edge (one cycle).
REQ-023 Throughput: one operation per cycle when RES_READY is held high.
REQ-024 Backpressure: while RES_VALID=1 and RES_READY=0, RES_S, RES_ID and RES_VALID hold, and the adder clock enable is 0.
REQ-025 RES_VALID clears on a result handshake with no simultaneous request handshake; on a simultaneous result and request handshake it stays 1 and the new result replaces the old one.
REQ-026 Arithmetic is unsigned; the carry out of bit W-1 is discarded. Example for W=28: 0xFFFFFFF+0x0000001 gives 0x0000000.
REQ-027 DONE_CNT increments by 1 per result handshake and saturates at 2^CW-1.
REQ-028 With no REQ_VALID asserted and no pending result, outputs hold and PTR does not move.

Reset
REQ-029 SCLR=1 at an edge sets RES_VALID=0, RES_S=0, RES_ID=0, PTR=0 and DONE_CNT=0; SCLR takes priority over all other updates.
REQ-030 While SCLR=1, REQ_READY is all-zero.
REQ-031 A result in flight or stalled when SCLR asserts is discarded, not delivered.
REQ-032 The first request after SCLR deasserts is accepted in the first cycle with SCLR=0.

Structure
REQ-033 The adder is one instance of adder28_un, with CE = request handshake, CLK and SCLR shared with this block, and W fixed at 28 for that instance; the arbiter, ID register, valid flag and counter are local to this block.
REQ-034 A shared package holds W, the default N_REQ and a function for requester-index width (clog2 of N_REQ); no typedefs are needed beyond these.
REQ-035 The round-robin grant logic is a natural separate sub-module, rr_arb (inputs: request vector, PTR; output: one-hot grant).

Verification
REQ-036 Single request: REQ_VALID=0001, A0=5, B0=7, RES_READY=1 -> REQ_READY=0001 at edge k; RES_VALID=1 after edge k with RES_S=12, RES_ID=0; DONE_CNT=1 after edge k+1.
REQ-037 Fairness: all four requesters valid continuously, RES_READY=1 -> grant order 0,1,2,3,0,... with one result per cycle and RES_ID following the same order.
REQ-038 Backpressure: result pending (RES_S=0x100, RES_ID=2), RES_READY=0 for 3 cycles with requester 1 valid -> RES_S and RES_ID hold, REQ_READY=0000; when RES_READY=1, requester 1 is granted in that same cycle.
REQ-039 Wrap: A=0xFFFFFFF, B=0x0000002 -> RES_S=0x0000001.
REQ-040 Reset mid-operation: SCLR pulsed on the edge after a handshake with requester 3 -> RES_VALID=0, DONE_CNT=0, the next grant starts its search at requester 0, and no stale result appears.
